// File: rtl/decode_stage_pkg.sv
// -----------------------------------------------------------------------------
// decode_stage_pkg
//   Shared definitions for the bgpu decode stage: the 8-bit opcode type, the
//   execution-unit and IU subtype encodings, the IU operand-class subtype sets
//   and a helper that maps an opcode to its operand-required mask.
//
//   Opcode layout: opcode[7:6] = execution unit, opcode[5:0] = subtype.
//   8'hFF (CTRL unit, subtype 6'h3F) is the warp stop instruction.
// -----------------------------------------------------------------------------

`ifndef BGPU_IU_TWO_REG_OPERANDS
`define BGPU_IU_TWO_REG_OPERANDS BGPU_IU_ADD, BGPU_IU_SUB, BGPU_IU_AND, BGPU_IU_OR, BGPU_IU_XOR, BGPU_IU_MUL
`endif

`ifndef BGPU_IU_REG_IMM_OPERANDS
`define BGPU_IU_REG_IMM_OPERANDS BGPU_IU_ADDI, BGPU_IU_SUBI, BGPU_IU_ANDI, BGPU_IU_SHLI
`endif

package decode_stage_pkg;

    typedef enum logic [1:0] {
        BGPU_UNIT_IU   = 2'd0,
        BGPU_UNIT_LSU  = 2'd1,
        BGPU_UNIT_BRU  = 2'd2,
        BGPU_UNIT_CTRL = 2'd3
    } bgpu_unit_e;

    typedef struct packed {
        bgpu_unit_e  unit;
        logic [5:0]  subtype;
    } bgpu_inst_t;

    // IU subtypes reading two registers
    localparam logic [5:0] BGPU_IU_ADD  = 6'h00;
    localparam logic [5:0] BGPU_IU_SUB  = 6'h01;
    localparam logic [5:0] BGPU_IU_AND  = 6'h02;
    localparam logic [5:0] BGPU_IU_OR   = 6'h03;
    localparam logic [5:0] BGPU_IU_XOR  = 6'h04;
    localparam logic [5:0] BGPU_IU_MUL  = 6'h05;
    // IU subtypes reading one register plus an immediate
    localparam logic [5:0] BGPU_IU_ADDI = 6'h10;
    localparam logic [5:0] BGPU_IU_SUBI = 6'h11;
    localparam logic [5:0] BGPU_IU_ANDI = 6'h12;
    localparam logic [5:0] BGPU_IU_SHLI = 6'h13;
    // IU subtype with no register source (load immediate)
    localparam logic [5:0] BGPU_IU_LDI  = 6'h20;

    localparam logic [7:0] BGPU_INST_STOP = 8'hFF;

    // Bit i set = operand field i must be read from the register file.
    // Operand 2 is only ever a register for LSU (address base + offset + data).
    function automatic logic [2:0] operands_required(bgpu_inst_t inst);
        logic [2:0] req;
        req = 3'b000;
        if (inst.unit == BGPU_UNIT_IU) begin
            if (inst.subtype inside {`BGPU_IU_TWO_REG_OPERANDS}) begin
                req = 3'b011;
            end else if (inst.subtype inside {`BGPU_IU_REG_IMM_OPERANDS}) begin
                req = 3'b001;
            end
        end else if (inst.unit == BGPU_UNIT_LSU) begin
            req = 3'b111;
        end
        return req;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// -----------------------------------------------------------------------------
// decode_stage_if
//   Instruction-cache -> decode and decode -> dispatcher buses.
//
//   Handshake rule (both buses): a transfer happens on a rising clock edge where
//   valid and ready are both high. The producer holds valid and payload stable
//   until the transfer; ready may not depend combinationally on valid.
//
//   Modports:
//     master : the surrounding pipeline (drives ic_* and disp_ready_i)
//     slave  : the decode stage (drives dec_*)
// -----------------------------------------------------------------------------
interface decode_stage_if
    import decode_stage_pkg::*;
#(
    parameter int PcWidth         = 32,
    parameter int NumWarps        = 8,
    parameter int WarpWidth       = 32,
    parameter int RegIdxWidth     = 8,
    parameter int OperandsPerInst = 2,
    parameter int EncInstWidth    = 8 + (1 + OperandsPerInst) * RegIdxWidth,
    localparam int WidWidth       = (NumWarps > 1) ? $clog2(NumWarps) : 1
) ();

    // instruction cache side
    logic                                   dec_ready_o;
    logic                                   ic_valid_i;
    logic [PcWidth-1:0]                     ic_pc_i;
    logic [WarpWidth-1:0]                   ic_act_mask_i;
    logic [WidWidth-1:0]                    ic_warp_id_i;
    logic [EncInstWidth-1:0]                ic_inst_i;

    // dispatcher side
    logic                                   disp_ready_i;
    logic                                   dec_valid_o;
    logic [PcWidth-1:0]                     dec_pc_o;
    logic [WarpWidth-1:0]                   dec_act_mask_o;
    logic [WidWidth-1:0]                    dec_warp_id_o;
    bgpu_inst_t                             dec_inst_o;
    logic [RegIdxWidth-1:0]                 dec_dst_o;
    logic [OperandsPerInst-1:0]             dec_operands_required_o;
    logic [OperandsPerInst*RegIdxWidth-1:0] dec_operands_o;

    modport master (
        output ic_valid_i, ic_pc_i, ic_act_mask_i, ic_warp_id_i, ic_inst_i, disp_ready_i,
        input  dec_ready_o, dec_valid_o, dec_pc_o, dec_act_mask_o, dec_warp_id_o,
               dec_inst_o, dec_dst_o, dec_operands_required_o, dec_operands_o
    );

    modport slave (
        input  ic_valid_i, ic_pc_i, ic_act_mask_i, ic_warp_id_i, ic_inst_i, disp_ready_i,
        output dec_ready_o, dec_valid_o, dec_pc_o, dec_act_mask_o, dec_warp_id_o,
               dec_inst_o, dec_dst_o, dec_operands_required_o, dec_operands_o
    );

endinterface

// File: rtl/decode_skid_buffer.sv
// -----------------------------------------------------------------------------
// decode_skid_buffer
//   Two-entry FIFO with valid/ready on both sides, payload type T.
//   in_ready_o comes straight from the occupancy register, so it never depends
//   on out_ready_i; two entries are enough to keep one transfer per cycle with
//   that registered ready.
//
//   Ports:
//     clk_i, rst_ni          clock, async active-low reset (empties the FIFO)
//     in_valid_i/in_ready_o  write side, in_data_i payload
//     out_valid_o/out_ready_i read side, out_data_o = oldest entry
// -----------------------------------------------------------------------------
module decode_skid_buffer #(
    parameter type T = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  T     in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output T     out_data_o
);

    T           mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       push;
    logic       pop;

    assign in_ready_o  = (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];

    assign push = in_valid_i && in_ready_o;
    assign pop  = out_valid_o && out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            // simultaneous push and pop leaves the occupancy unchanged
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   Decodes bgpu instructions coming from the instruction cache into a 2-entry
//   skid buffer feeding the dispatcher, tracks a per-warp stopped mask and
//   notifies the fetcher of every decoded instruction.
//
//   Ports:
//     clk_i, rst_ni             clock, async active-low reset
//     bus (decode_stage_if.slave) ic_* input bus and dec_* dispatcher bus
//     warp_start_i/_id_i        warp (re)launch, clears its stopped bit
//     warp_stopped_o            stopped bitmask, one bit per warp
//     dec_decoded_o             fetcher notification, same cycle as the accept
//     dec_stop_warp_o           the notified instruction was a stop
//     dec_decoded_warp_id_o     warp of the notified instruction
//     dec_decoded_next_pc_o     pc + 1 (wraps)
//
//   Optional: define DECODE_STAGE_PERF_EN to add perf_decoded_o (buffer
//   writes) and perf_dropped_o (instructions of stopped warps), both
//   saturating 32-bit counters.
//
//   Instruction field layout, MSB down: opcode[8], dst, operand 0 .. N-1.
//   On dec_operands_o operand i sits at [i*RegIdxWidth +: RegIdxWidth], so it
//   lines up with bit i of dec_operands_required_o.
// -----------------------------------------------------------------------------
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int PcWidth         = 32,
    parameter int NumWarps        = 8,
    parameter int WarpWidth       = 32,
    parameter int RegIdxWidth     = 8,
    parameter int OperandsPerInst = 2,
    parameter int EncInstWidth    = 8 + (1 + OperandsPerInst) * RegIdxWidth,
    localparam int WidWidth       = (NumWarps > 1) ? $clog2(NumWarps) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    decode_stage_if.slave       bus,
    input  logic                warp_start_i,
    input  logic [WidWidth-1:0] warp_start_id_i,
    output logic [NumWarps-1:0] warp_stopped_o,
    output logic                dec_decoded_o,
    output logic                dec_stop_warp_o,
    output logic [WidWidth-1:0] dec_decoded_warp_id_o,
    output logic [PcWidth-1:0]  dec_decoded_next_pc_o
`ifdef DECODE_STAGE_PERF_EN
    ,
    output logic [31:0]         perf_decoded_o,
    output logic [31:0]         perf_dropped_o
`endif
);

    typedef logic [WidWidth-1:0]    wid_t;
    typedef logic [RegIdxWidth-1:0] reg_idx_t;
    typedef logic [PcWidth-1:0]     pc_t;
    typedef logic [WarpWidth-1:0]   act_mask_t;

    typedef struct packed {
        pc_t                                    pc;
        act_mask_t                              mask;
        wid_t                                   wid;
        bgpu_inst_t                             inst;
        reg_idx_t                               dst;
        logic [OperandsPerInst-1:0]             req;
        logic [OperandsPerInst*RegIdxWidth-1:0] operands;
    } entry_t;

`ifndef SYNTHESIS
    if (EncInstWidth != 8 + (1 + OperandsPerInst) * RegIdxWidth) begin : g_enc_width_check
        $error("decode_stage: EncInstWidth must equal 8+(1+OperandsPerInst)*RegIdxWidth");
    end
    if (OperandsPerInst < 1 || OperandsPerInst > 3) begin : g_operands_check
        $error("decode_stage: OperandsPerInst must be in 1..3");
    end
`endif

    logic [NumWarps-1:0]                    stopped_q;
    logic [NumWarps-1:0]                    stopped_d;
    bgpu_inst_t                             ic_op;
    reg_idx_t                               ic_dst;
    logic [OperandsPerInst*RegIdxWidth-1:0] ic_operands;
    logic                                   accept;
    logic                                   is_stop;
    logic                                   warp_is_stopped;
    logic                                   buf_write;
    logic                                   buf_ready;
    logic                                   buf_valid;
    entry_t                                 wr_entry;
    entry_t                                 rd_entry;

    // ---------------- field extraction ----------------
    assign ic_op  = bgpu_inst_t'(bus.ic_inst_i[EncInstWidth-1 -: 8]);
    assign ic_dst = bus.ic_inst_i[EncInstWidth-9 -: RegIdxWidth];

    // operand 0 is the most significant operand field of the encoding
    always_comb begin
        ic_operands = '0;
        for (int i = 0; i < OperandsPerInst; i++) begin
            ic_operands[i*RegIdxWidth +: RegIdxWidth] =
                bus.ic_inst_i[(OperandsPerInst-1-i)*RegIdxWidth +: RegIdxWidth];
        end
    end

    always_comb begin
        warp_is_stopped = 1'b0;
        for (int w = 0; w < NumWarps; w++) begin
            if (bus.ic_warp_id_i == wid_t'(w)) begin
                warp_is_stopped = stopped_q[w];
            end
        end
    end

    assign accept    = bus.ic_valid_i && buf_ready;
    assign is_stop   = (ic_op == bgpu_inst_t'(BGPU_INST_STOP));
    // stops and instructions of stopped warps are consumed but never buffered
    assign buf_write = accept && !is_stop && !warp_is_stopped;

    always_comb begin
        wr_entry          = '0;
        wr_entry.pc       = bus.ic_pc_i;
        wr_entry.mask     = bus.ic_act_mask_i;
        wr_entry.wid      = bus.ic_warp_id_i;
        wr_entry.inst     = ic_op;
        wr_entry.dst      = ic_dst;
        wr_entry.req      = (OperandsPerInst)'(operands_required(ic_op));
        wr_entry.operands = ic_operands;
    end

    // ---------------- stopped mask ----------------
    // a start for the same warp overrides a stop accepted in the same cycle
    always_comb begin
        stopped_d = stopped_q;
        for (int w = 0; w < NumWarps; w++) begin
            if (warp_start_i && warp_start_id_i == wid_t'(w)) begin
                stopped_d[w] = 1'b0;
            end else if (accept && is_stop && bus.ic_warp_id_i == wid_t'(w)) begin
                stopped_d[w] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stopped_q <= '0;
        end else begin
            stopped_q <= stopped_d;
        end
    end

    assign warp_stopped_o = stopped_q;

    // ---------------- fetcher notification ----------------
    // a stop is always reported, even if its warp was already stopped
    assign dec_decoded_o         = accept && (is_stop || !warp_is_stopped);
    assign dec_stop_warp_o       = accept && is_stop;
    assign dec_decoded_warp_id_o = bus.ic_warp_id_i;
    assign dec_decoded_next_pc_o = bus.ic_pc_i + pc_t'(1);

    // ---------------- skid buffer ----------------
    decode_skid_buffer #(
        .T (entry_t)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (buf_write),
        .in_ready_o  (buf_ready),
        .in_data_i   (wr_entry),
        .out_valid_o (buf_valid),
        .out_ready_i (bus.disp_ready_i),
        .out_data_o  (rd_entry)
    );

    assign bus.dec_ready_o             = buf_ready;
    assign bus.dec_valid_o             = buf_valid;
    assign bus.dec_pc_o                = rd_entry.pc;
    assign bus.dec_act_mask_o          = rd_entry.mask;
    assign bus.dec_warp_id_o           = rd_entry.wid;
    assign bus.dec_inst_o              = rd_entry.inst;
    assign bus.dec_dst_o               = rd_entry.dst;
    assign bus.dec_operands_required_o = rd_entry.req;
    assign bus.dec_operands_o          = rd_entry.operands;

`ifdef DECODE_STAGE_PERF_EN
    logic drop;
    assign drop = accept && !is_stop && warp_is_stopped;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_decoded_o <= '0;
            perf_dropped_o <= '0;
        end else begin
            if (buf_write && perf_decoded_o != 32'hFFFF_FFFF) begin
                perf_decoded_o <= perf_decoded_o + 32'd1;
            end
            if (drop && perf_dropped_o != 32'hFFFF_FFFF) begin
                perf_dropped_o <= perf_dropped_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//   Directed bench for decode_stage with default parameters
//   (PcWidth 32, NumWarps 8, WarpWidth 32, RegIdxWidth 8, OperandsPerInst 2).
//   Driver tasks push expected dispatcher entries into exp_q; a negedge monitor
//   pops and compares whenever the dispatcher handshake completes.
// -----------------------------------------------------------------------------
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam int W = 32 + 32 + 3 + 8 + 8 + 2 + 16;

    logic clk = 1'b0;
    logic rst_n;
    logic       warp_start;
    logic [2:0] warp_start_id;
    logic [7:0] warp_stopped;
    logic       decoded;
    logic       stop_warp;
    logic [2:0] decoded_wid;
    logic [31:0] decoded_next_pc;
`ifdef DECODE_STAGE_PERF_EN
    logic [31:0] perf_decoded;
    logic [31:0] perf_dropped;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;
    logic [W-1:0] mon_act;

    decode_stage_if bus ();

    decode_stage dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .bus                   (bus),
        .warp_start_i          (warp_start),
        .warp_start_id_i       (warp_start_id),
        .warp_stopped_o        (warp_stopped),
        .dec_decoded_o         (decoded),
        .dec_stop_warp_o       (stop_warp),
        .dec_decoded_warp_id_o (decoded_wid),
        .dec_decoded_next_pc_o (decoded_next_pc)
`ifdef DECODE_STAGE_PERF_EN
        ,
        .perf_decoded_o        (perf_decoded),
        .perf_dropped_o        (perf_dropped)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && bus.dec_valid_o && bus.disp_ready_i) begin
            mon_act = {bus.dec_pc_o, bus.dec_act_mask_o, bus.dec_warp_id_o, bus.dec_inst_o,
                       bus.dec_dst_o, bus.dec_operands_required_o, bus.dec_operands_o};
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_dispatch: got %h expected nothing (t=%0t)", mon_act, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("dispatch", {27'd0, mon_act}, {27'd0, mon_exp});
            end
        end
    end

    // ---------------- driver ----------------
    // Presents one instruction, checks the fetcher notification in its accept
    // cycle and, if it should reach the dispatcher, queues the expected entry.
    task automatic issue(input logic [7:0] op, input logic [7:0] dst, input logic [7:0] o0,
                         input logic [7:0] o1, input logic [2:0] wid, input logic [31:0] pc,
                         input logic [1:0] req, input logic exp_dec, input logic exp_stop,
                         input logic exp_out);
        logic [31:0] mask;
        logic        got;
        mask = {~pc[15:0], pc[15:0]};
        bus.ic_valid_i    = 1'b1;
        bus.ic_pc_i       = pc;
        bus.ic_act_mask_i = mask;
        bus.ic_warp_id_i  = wid;
        bus.ic_inst_i     = {op, dst, o0, o1};
        got = 1'b0;
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clk);
            if (bus.dec_ready_o) got = 1'b1;
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: pc %h never accepted (t=%0t)", pc, $time);
        end else begin
            check("decoded_pulse", {127'd0, decoded}, {127'd0, exp_dec});
            check("stop_pulse", {127'd0, stop_warp}, {127'd0, exp_stop});
            check("decoded_wid", {125'd0, decoded_wid}, {125'd0, wid});
            check("next_pc", {96'd0, decoded_next_pc}, {96'd0, pc + 32'd1});
            if (exp_out) exp_q.push_back({pc, mask, wid, op, dst, req, o1, o0});
            @(posedge clk);
        end
        #1;
        bus.ic_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n             = 1'b1;
        warp_start        = 1'b0;
        warp_start_id     = 3'd0;
        bus.ic_valid_i    = 1'b0;
        bus.ic_pc_i       = '0;
        bus.ic_act_mask_i = '0;
        bus.ic_warp_id_i  = '0;
        bus.ic_inst_i     = '0;
        bus.disp_ready_i  = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {127'd0, bus.dec_valid_o}, 128'd0);
        check("rst_ready", {127'd0, bus.dec_ready_o}, 128'd1);
        check("rst_stopped", {120'd0, warp_stopped}, 128'd0);
        check("rst_pc", {96'd0, bus.dec_pc_o}, 128'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // IU add, wid 3, pc 0x10: entry visible one cycle after accept
        issue(8'h00, 8'h05, 8'h07, 8'h09, 3'd3, 32'h10, 2'b11, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("latency1_valid", {127'd0, bus.dec_valid_o}, 128'd1);
        @(posedge clk);
        #1;
        // operand classes: reg-imm, LSU, BRU, IU without register source
        issue(8'h10, 8'h11, 8'h12, 8'h13, 3'd5, 32'h20, 2'b01, 1'b1, 1'b0, 1'b1);
        issue(8'h40, 8'h21, 8'h22, 8'h23, 3'd6, 32'h21, 2'b11, 1'b1, 1'b0, 1'b1);
        issue(8'h80, 8'h31, 8'h32, 8'h33, 3'd7, 32'h22, 2'b00, 1'b1, 1'b0, 1'b1);
        issue(8'h20, 8'h41, 8'h42, 8'h43, 3'd0, 32'h23, 2'b00, 1'b1, 1'b0, 1'b1);
        wait_drain();

        // backpressure: two entries fill the buffer, the third waits
        bus.disp_ready_i = 1'b0;
        fork
            begin
                issue(8'h00, 8'h51, 8'h52, 8'h53, 3'd0, 32'h100, 2'b11, 1'b1, 1'b0, 1'b1);
                issue(8'h41, 8'h61, 8'h62, 8'h63, 3'd1, 32'h101, 2'b11, 1'b1, 1'b0, 1'b1);
                issue(8'h11, 8'h71, 8'h72, 8'h73, 3'd2, 32'h102, 2'b01, 1'b1, 1'b0, 1'b1);
            end
            begin
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                check("full_ready", {127'd0, bus.dec_ready_o}, 128'd0);
                check("full_valid", {127'd0, bus.dec_valid_o}, 128'd1);
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("hold_ready", {127'd0, bus.dec_ready_o}, 128'd0);
                check("hold_pc", {96'd0, bus.dec_pc_o}, {96'd0, 32'h100});
                @(posedge clk);
                #1;
                bus.disp_ready_i = 1'b1;
            end
        join
        wait_drain();

        // stop on warp 2, its later instructions are dropped, warp 1 passes
        issue(8'hFF, 8'h00, 8'h00, 8'h00, 3'd2, 32'h200, 2'b00, 1'b1, 1'b1, 1'b0);
        issue(8'h00, 8'h01, 8'h02, 8'h03, 3'd2, 32'h201, 2'b11, 1'b0, 1'b0, 1'b0);
        issue(8'h40, 8'h04, 8'h05, 8'h06, 3'd2, 32'h202, 2'b11, 1'b0, 1'b0, 1'b0);
        issue(8'h02, 8'h07, 8'h08, 8'h09, 3'd1, 32'h203, 2'b11, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("stopped_w2", {120'd0, warp_stopped}, {120'd0, 8'b0000_0100});
        @(posedge clk);
        #1;

        // start and stop for warp 2 in the same cycle: start wins
        warp_start    = 1'b1;
        warp_start_id = 3'd2;
        issue(8'hFF, 8'h00, 8'h00, 8'h00, 3'd2, 32'h300, 2'b00, 1'b1, 1'b1, 1'b0);
        warp_start = 1'b0;
        @(negedge clk);
        check("start_wins", {120'd0, warp_stopped}, 128'd0);
        @(posedge clk);
        #1;
        issue(8'h03, 8'h0A, 8'h0B, 8'h0C, 3'd2, 32'h301, 2'b11, 1'b1, 1'b0, 1'b1);

        // stop then a separate start on warp 6
        issue(8'hFF, 8'h00, 8'h00, 8'h00, 3'd6, 32'h400, 2'b00, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("stopped_w6", {120'd0, warp_stopped}, {120'd0, 8'b0100_0000});
        @(posedge clk);
        #1;
        warp_start    = 1'b1;
        warp_start_id = 3'd6;
        @(posedge clk);
        #1;
        warp_start = 1'b0;
        @(negedge clk);
        check("restart_w6", {120'd0, warp_stopped}, 128'd0);
        @(posedge clk);
        #1;

        // pc wrap
        issue(8'h01, 8'h0D, 8'h0E, 8'h0F, 3'd0, 32'hFFFF_FFFF, 2'b11, 1'b1, 1'b0, 1'b1);
        wait_drain();

        // reset with two buffered entries and a stopped warp
        issue(8'hFF, 8'h00, 8'h00, 8'h00, 3'd7, 32'h500, 2'b00, 1'b1, 1'b1, 1'b0);
        bus.disp_ready_i = 1'b0;
        issue(8'h00, 8'h11, 8'h22, 8'h33, 3'd0, 32'h501, 2'b11, 1'b1, 1'b0, 1'b0);
        issue(8'h00, 8'h44, 8'h55, 8'h66, 3'd1, 32'h502, 2'b11, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("pre_reset_valid", {127'd0, bus.dec_valid_o}, 128'd1);
        check("pre_reset_ready", {127'd0, bus.dec_ready_o}, 128'd0);
        check("pre_reset_stopped", {120'd0, warp_stopped}, {120'd0, 8'b1000_0000});
        #2 rst_n = 1'b0;
        #1;
        check("reset_valid_now", {127'd0, bus.dec_valid_o}, 128'd0);
        check("reset_stopped_now", {120'd0, warp_stopped}, 128'd0);
        check("reset_pc_now", {96'd0, bus.dec_pc_o}, 128'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.disp_ready_i = 1'b1;
        @(negedge clk);
        check("post_reset_ready", {127'd0, bus.dec_ready_o}, 128'd1);
        check("post_reset_valid", {127'd0, bus.dec_valid_o}, 128'd0);
        @(posedge clk);
        #1;

        // 5 dispatched + 3 dropped after reset
        issue(8'hFF, 8'h00, 8'h00, 8'h00, 3'd4, 32'h600, 2'b00, 1'b1, 1'b1, 1'b0);
        issue(8'h00, 8'h01, 8'h01, 8'h01, 3'd4, 32'h601, 2'b11, 1'b0, 1'b0, 1'b0);
        issue(8'h00, 8'h02, 8'h02, 8'h02, 3'd0, 32'h602, 2'b11, 1'b1, 1'b0, 1'b1);
        issue(8'h10, 8'h03, 8'h03, 8'h03, 3'd4, 32'h603, 2'b01, 1'b0, 1'b0, 1'b0);
        issue(8'h10, 8'h04, 8'h04, 8'h04, 3'd1, 32'h604, 2'b01, 1'b1, 1'b0, 1'b1);
        issue(8'h40, 8'h05, 8'h05, 8'h05, 3'd3, 32'h605, 2'b11, 1'b1, 1'b0, 1'b1);
        issue(8'h40, 8'h06, 8'h06, 8'h06, 3'd4, 32'h606, 2'b11, 1'b0, 1'b0, 1'b0);
        issue(8'h80, 8'h07, 8'h07, 8'h07, 3'd5, 32'h607, 2'b00, 1'b1, 1'b0, 1'b1);
        issue(8'h04, 8'h08, 8'h08, 8'h08, 3'd7, 32'h608, 2'b11, 1'b1, 1'b0, 1'b1);
        wait_drain();
`ifdef DECODE_STAGE_PERF_EN
        check("perf_decoded", {96'd0, perf_decoded}, 128'd5);
        check("perf_dropped", {96'd0, perf_dropped}, 128'd3);
`endif

        check("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Buffered, parametrised decode stage between the instruction cache and the dispatcher.
- Decodes the bgpu opcode, destination and N operand fields into a 2-entry skid buffer, so a registered dispatcher interface keeps full throughput.
- Keeps a per-warp "stopped" bitmask: in-flight instructions of a stopped warp are dropped.
- Reports decode and stop events to the fetcher.

Parameters:
- PcWidth, 32, program counter width
- NumWarps, 8, warps per compute unit
- WarpWidth, 32, threads per warp
- RegIdxWidth, 8, register index width
- OperandsPerInst, 2, operand fields per instruction (1..3)
- EncInstWidth, 8+(1+OperandsPerInst)*RegIdxWidth, encoded instruction width; must equal this formula
- Derived, do not override: WidWidth = NumWarps>1 ? $clog2(NumWarps) : 1; wid_t, reg_idx_t, pc_t, act_mask_t, enc_inst_t

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- dec_ready_o  out  1  accept instruction from the instruction cache
- ic_valid_i  in  1  instruction valid
- ic_pc_i  in  PcWidth  PC
- ic_act_mask_i  in  WarpWidth  active mask
- ic_warp_id_i  in  WidWidth  warp id
- ic_inst_i  in  EncInstWidth  encoded instruction
- disp_ready_i  in  1  dispatcher ready
- dec_valid_o  out  1  decoded entry valid
- dec_pc_o  out  PcWidth
- dec_act_mask_o  out  WarpWidth
- dec_warp_id_o  out  WidWidth
- dec_inst_o  out  bgpu_inst_t  opcode
- dec_dst_o  out  RegIdxWidth
- dec_operands_required_o  out  OperandsPerInst
- dec_operands_o  out  OperandsPerInst*RegIdxWidth
- warp_start_i  in  1  warp (re)launch; clears the stopped bit
- warp_start_id_i  in  WidWidth
- warp_stopped_o  out  NumWarps  stopped bitmask
- dec_decoded_o  out  1  fetcher notification pulse
- dec_stop_warp_o  out  1  the notified instruction was a stop
- dec_decoded_warp_id_o  out  WidWidth
- dec_decoded_next_pc_o  out  PcWidth  pc+1, wraps modulo 2^PcWidth

Behaviour:
- Field layout, MSB down: opcode[8], dst[RegIdxWidth], then operand 0..N-1 at RegIdxWidth each.
- Stop instruction: opcode == 8'hFF.
- Operands-required rules:
  - IU subtypes in BGPU_IU_TWO_REG_OPERANDS: all 1.
  - IU subtypes in BGPU_IU_REG_IMM_OPERANDS: operand0 only.
  - LSU: all 1.
  - Anything else: 0.
  - For OperandsPerInst=3, operand2 is required only for LSU.
- Input handshake accept = ic_valid_i && dec_ready_o.
- dec_ready_o = buffer count < 2. It is registered and does not depend on disp_ready_i.
- Skid buffer: 2 entries, FIFO order.
  - Accepted non-stop instruction from a non-stopped warp is written decoded; dec_valid_o rises the next cycle (latency 1).
  - Output handshake = dec_valid_o && disp_ready_i.
  - Accept and output in the same cycle with count 1: count stays 1.
  - Count 2: dec_ready_o=0.
  - Outputs hold stable while dec_valid_o && !disp_ready_i.
- Stop handling:
  - Accepted stop sets stopped[wid] at the next edge.
  - The stop is never written to the buffer.
  - In the accept cycle, combinationally: dec_decoded_o=1, dec_stop_warp_o=1.
- Dropped instruction: accepted while stopped[wid]=1. It is consumed with dec_decoded_o=0 and no buffer write.
- Non-stop, non-dropped accept: dec_decoded_o=1 in the accept cycle (not on dispatch), dec_stop_warp_o=0.
- dec_decoded_warp_id_o and dec_decoded_next_pc_o are taken from the ic_* inputs.
- warp_start_i clears stopped[warp_start_id_i] at the next edge.
- warp_start_i and a stop for the same warp in the same cycle: start wins, bit ends 0. The stop pulse is still reported.
- Reset values, async on rst_ni low:
  - buffer count 0, dec_valid_o=0, dec_ready_o=1, warp_stopped_o='0.
  - Payload registers 0.
  - Reset mid-transfer discards buffered entries.

Optional Feature:
- Macro DECODE_STAGE_PERF_EN.
- When defined, adds outputs perf_decoded_o [32] and perf_dropped_o [32].
  - perf_decoded_o counts buffer writes.
  - perf_dropped_o counts dropped instructions.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- bgpu_pkg / instructions.svh holds: bgpu_inst_t, the IU subtype set macros, BGPU_INST_STOP = 8'hFF, and the decoded-entry struct typedef (pc, mask, wid, inst, dst, req, operands).
- Sub-module decode_skid_buffer: a 2-entry valid/ready FIFO parametrised by payload type. The decode logic stays in decode_stage.
- Elaboration asserts, under non-SYNTHESIS:
  - EncInstWidth formula holds.
  - 1 <= OperandsPerInst <= 3.

Test Plan:
- IU add (two-reg), wid 3, pc 0x10, disp_ready=1 -> dec_valid_o next cycle; dst/operands match the fields; req=2'b11; dec_decoded_o pulse in the accept cycle with next_pc 0x11.
- disp_ready=0, three back-to-back valid instructions -> first two accepted, dec_ready_o=0 from the 3rd cycle. Release ready -> the three dispatched in order, no bubbles or duplicates.
- Stop (0xFF) on wid 2, then two instructions on wid 2 and one on wid 1 -> warp_stopped_o=8'b0000_0100; dec_stop_warp_o pulse; wid-2 instructions dropped with no dec_decoded_o; wid 1 dispatched.
- warp_start_i wid 2 in the same cycle as a wid-2 stop accept -> bit stays 0; the next wid-2 instruction is dispatched.
- pc = 0xFFFFFFFF -> dec_decoded_next_pc_o=0. Assert rst_ni mid-stream with 2 entries buffered -> dec_valid_o=0 immediately; dec_ready_o=1 after reset.
- With DECODE_STAGE_PERF_EN: 5 dispatched + 3 dropped -> perf_decoded_o=5, perf_dropped_o=3.
